// File: rtl/sublime_pkg.sv
// Shared Wishbone constants, DMA state encoding and data helpers for the wavetable DMA.
package sublime_pkg;

    localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
    localparam logic [2:0] WB_CTI_INCR    = 3'b010;
    localparam logic [2:0] WB_CTI_EOB     = 3'b111;
    localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2,
        FLUSH = 2'd3
    } dma_state_e;

    function automatic logic [31:0] byteswap32(input logic [31:0] word);
        return {word[7:0], word[15:8], word[23:16], word[31:24]};
    endfunction

endpackage

// File: rtl/sublime_wb_burst_master.sv
// Wishbone B3 read-burst sequencer: drives cyc/stb/cti/adr for one incrementing burst
// and reports each accepted beat plus the burst outcome to the DMA controller.
module sublime_wb_burst_master
    import sublime_pkg::*;
#(
    parameter int ADR_W = 32,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             burst_start,
    input  logic [ADR_W-1:0] base_addr,
    input  logic [CNT_W-1:0] beat_count,
    output logic             wb_cyc,
    output logic             wb_stb,
    output logic [2:0]       wb_cti,
    output logic [ADR_W-1:0] wb_adr,
    input  logic             wb_ack,
    input  logic             wb_err,
    input  logic             wb_rty,
    output logic             beat_ack,
    output logic             burst_done,
    output logic             burst_err,
    output logic             burst_rty
);

    logic             cyc_r;
    logic [2:0]       cti_r;
    logic [ADR_W-1:0] adr_r;
    logic [CNT_W-1:0] beats_left_r;

    // Classify the slave response; err beats rty beats ack, and nothing counts while idle.
    always_comb begin
        beat_ack   = 1'b0;
        burst_done = 1'b0;
        burst_err  = 1'b0;
        burst_rty  = 1'b0;
        if (cyc_r) begin
            burst_err  = wb_err;
            burst_rty  = wb_rty & ~wb_err;
            beat_ack   = wb_ack & ~wb_err & ~wb_rty;
            burst_done = wb_ack & ~wb_err & ~wb_rty & (beats_left_r == CNT_W'(1));
        end else begin
            beat_ack   = 1'b0;
        end
    end

    // Burst sequencing: open on request, advance per ack, close on last beat, err or rty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_r        <= 1'b0;
            cti_r        <= WB_CTI_CLASSIC;
            adr_r        <= '0;
            beats_left_r <= '0;
        end else if (burst_start) begin
            cyc_r        <= 1'b1;
            adr_r        <= base_addr;
            beats_left_r <= beat_count;
            cti_r        <= (beat_count == CNT_W'(1)) ? WB_CTI_EOB : WB_CTI_INCR;
        end else if (cyc_r) begin
            if (wb_err || wb_rty) begin
                cyc_r <= 1'b0;
                cti_r <= WB_CTI_CLASSIC;
            end else if (wb_ack) begin
                adr_r        <= adr_r + ADR_W'(4);
                beats_left_r <= beats_left_r - CNT_W'(1);
                if (beats_left_r == CNT_W'(1)) begin
                    cyc_r <= 1'b0;
                    cti_r <= WB_CTI_CLASSIC;
                end else if (beats_left_r == CNT_W'(2)) begin
                    cti_r <= WB_CTI_EOB;
                end else begin
                    cti_r <= cti_r;
                end
            end else begin
                cyc_r <= cyc_r;
            end
        end else begin
            cyc_r <= 1'b0;
        end
    end

    assign wb_cyc = cyc_r;
    assign wb_stb = cyc_r;
    assign wb_cti = cti_r;
    assign wb_adr = adr_r;

endmodule

// File: rtl/sublime_wavetable_dma.sv
// Wishbone DMA that copies words from memory into wavetable0/1 using incrementing bursts.
// Define SUBLIME_WAVETABLE_DMA_BYTESWAP_EN to byte-reverse each word for big-endian images.
module sublime_wavetable_dma
    import sublime_pkg::*;
#(
    parameter int WAVETABLE_SIZE = 8192,
    parameter int WB_AW          = 32,
    parameter int WB_DW          = 32,
    parameter int BURST_LEN      = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [WB_AW-1:0]                  src_addr,
    input  logic [$clog2(WAVETABLE_SIZE):0]   length,
    input  logic                              dst_table,
    input  logic [$clog2(WAVETABLE_SIZE)-1:0] dst_offset,
    output logic                              busy,
    output logic                              done,
    output logic                              error,
    output logic                              wavetable0_we,
    output logic                              wavetable1_we,
    output logic [$clog2(WAVETABLE_SIZE)-1:0] wavetable_write_addr,
    output logic [31:0]                       wavetable_write_data,
    output logic [WB_AW-1:0]                  wbm_adr_o,
    output logic [3:0]                        wbm_sel_o,
    output logic                              wbm_we_o,
    output logic                              wbm_cyc_o,
    output logic                              wbm_stb_o,
    output logic [2:0]                        wbm_cti_o,
    output logic [1:0]                        wbm_bte_o,
    input  logic [31:0]                       wbm_dat_i,
    input  logic                              wbm_ack_i,
    input  logic                              wbm_err_i,
    input  logic                              wbm_rty_i
);

    localparam int AW  = $clog2(WAVETABLE_SIZE);
    localparam int RW  = AW + 1;
    localparam int BCW = $clog2(BURST_LEN) + 1;
    localparam logic [WB_AW-1:0] WORD_MASK = {{(WB_AW-2){1'b1}}, 2'b00};

    dma_state_e       state_r;
    logic [RW-1:0]    remaining_r;
    logic [WB_AW-1:0] src_next_r;
    logic [AW-1:0]    dst_addr_r;
    logic             dst_table_r;
    logic             busy_r;
    logic             done_r;
    logic             error_r;
    logic             we0_r;
    logic             we1_r;
    logic [AW-1:0]    wr_addr_r;
    logic [31:0]      wr_data_r;

    logic             burst_start_s;
    logic [WB_AW-1:0] burst_base_s;
    logic [BCW-1:0]   burst_count_s;
    logic             beat_ack_s;
    logic             burst_done_s;
    logic             burst_err_s;
    logic             burst_rty_s;
    logic [31:0]      beat_data_s;

    function automatic logic [BCW-1:0] clip_beats(input logic [RW-1:0] words);
        if (words >= RW'(BURST_LEN)) begin
            return BCW'(BURST_LEN);
        end else begin
            return words[BCW-1:0];
        end
    endfunction

`ifdef SUBLIME_WAVETABLE_DMA_BYTESWAP_EN
    assign beat_data_s = byteswap32(wbm_dat_i);
`else
    assign beat_data_s = wbm_dat_i;
`endif

    // Launch a burst straight from an accepted start, or after the one-cycle arbitration gap.
    always_comb begin
        burst_start_s = 1'b0;
        burst_base_s  = src_next_r;
        burst_count_s = clip_beats(remaining_r);
        case (state_r)
            IDLE: begin
                if (start && (length != '0)) begin
                    burst_start_s = 1'b1;
                    burst_base_s  = src_addr & WORD_MASK;
                    burst_count_s = clip_beats(length);
                end else begin
                    burst_start_s = 1'b0;
                end
            end
            GAP:     burst_start_s = 1'b1;
            default: burst_start_s = 1'b0;
        endcase
    end

    sublime_wb_burst_master #(
        .ADR_W (WB_AW),
        .CNT_W (BCW)
    ) u_burst (
        .clk         (clk),
        .rst_n       (rst),
        .burst_start (burst_start_s),
        .base_addr   (burst_base_s),
        .beat_count  (burst_count_s),
        .wb_cyc      (wbm_cyc_o),
        .wb_stb      (wbm_stb_o),
        .wb_cti      (wbm_cti_o),
        .wb_adr      (wbm_adr_o),
        .wb_ack      (wbm_ack_i),
        .wb_err      (wbm_err_i),
        .wb_rty      (wbm_rty_i),
        .beat_ack    (beat_ack_s),
        .burst_done  (burst_done_s),
        .burst_err   (burst_err_s),
        .burst_rty   (burst_rty_s)
    );

    // Transfer FSM with length/destination bookkeeping and the registered write port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            remaining_r <= '0;
            src_next_r  <= '0;
            dst_addr_r  <= '0;
            dst_table_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
            we0_r       <= 1'b0;
            we1_r       <= 1'b0;
            wr_addr_r   <= '0;
            wr_data_r   <= 32'd0;
        end else begin
            done_r <= 1'b0;
            we0_r  <= 1'b0;
            we1_r  <= 1'b0;
            if (beat_ack_s) begin
                wr_data_r <= beat_data_s;
                wr_addr_r <= dst_addr_r;
                we0_r     <= ~dst_table_r;
                we1_r     <= dst_table_r;
            end else begin
                wr_data_r <= wr_data_r;
            end
            case (state_r)
                IDLE: begin
                    if (start) begin
                        error_r     <= 1'b0;
                        src_next_r  <= src_addr & WORD_MASK;
                        remaining_r <= length;
                        dst_addr_r  <= dst_offset;
                        dst_table_r <= dst_table;
                        if (length == '0) begin
                            done_r <= 1'b1;
                        end else begin
                            busy_r  <= 1'b1;
                            state_r <= BURST;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BURST: begin
                    if (burst_err_s) begin
                        error_r     <= 1'b1;
                        remaining_r <= '0;
                        state_r     <= FLUSH;
                    end else if (burst_rty_s) begin
                        state_r <= GAP;
                    end else if (beat_ack_s) begin
                        remaining_r <= remaining_r - RW'(1);
                        dst_addr_r  <= dst_addr_r + AW'(1);
                        src_next_r  <= src_next_r + WB_AW'(4);
                        if (burst_done_s) begin
                            state_r <= (remaining_r == RW'(1)) ? FLUSH : GAP;
                        end else begin
                            state_r <= BURST;
                        end
                    end else begin
                        state_r <= BURST;
                    end
                end
                GAP: state_r <= BURST;
                FLUSH: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                    state_r <= IDLE;
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    assign busy                 = busy_r;
    assign done                 = done_r;
    assign error                = error_r;
    assign wavetable0_we        = we0_r;
    assign wavetable1_we        = we1_r;
    assign wavetable_write_addr = wr_addr_r;
    assign wavetable_write_data = wr_data_r;
    assign wbm_sel_o            = 4'hf;
    assign wbm_we_o             = 1'b0;
    assign wbm_bte_o            = WB_BTE_LINEAR;

endmodule

// File: tb/tb_sublime_wavetable_dma.sv
// Directed bench for sublime_wavetable_dma with a zero-wait Wishbone slave and err/rty injection.
module tb_sublime_wavetable_dma;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] src_addr = 32'd0;
    logic [13:0] length = 14'd0;
    logic        dst_table = 1'b0;
    logic [12:0] dst_offset = 13'd0;
    logic        busy, done, error, we0, we1;
    logic [12:0] wr_addr;
    logic [31:0] wr_data;
    logic [31:0] wbm_adr_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
    logic [2:0]  wbm_cti_o;
    logic [1:0]  wbm_bte_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i, wbm_err_i, wbm_rty_i;

    logic [1:0]  inj_mode = 2'd0;
    int          inj_idx = 0;
    int          attempt = 0;
    logic        stray = 1'b0;

    int          total = 0;
    int          bad = 0;

    logic [12:0] w0_addr[$];
    logic [31:0] w0_data[$];
    logic [12:0] w1_addr[$];
    logic [31:0] w1_data[$];
    logic [31:0] beat_adr[$];
    logic [2:0]  beat_cti[$];
    int          gaps[$];
    int          burst_cnt = 0;
    int          done_cnt = 0;
    int          low_run = 0;
    logic        prev_cyc = 1'b0;
    logic        had_burst = 1'b0;

    always #5 clk = ~clk;

    sublime_wavetable_dma dut (
        .clk                  (clk),
        .rst                  (rst),
        .start                (start),
        .src_addr             (src_addr),
        .length               (length),
        .dst_table            (dst_table),
        .dst_offset           (dst_offset),
        .busy                 (busy),
        .done                 (done),
        .error                (error),
        .wavetable0_we        (we0),
        .wavetable1_we        (we1),
        .wavetable_write_addr (wr_addr),
        .wavetable_write_data (wr_data),
        .wbm_adr_o            (wbm_adr_o),
        .wbm_sel_o            (wbm_sel_o),
        .wbm_we_o             (wbm_we_o),
        .wbm_cyc_o            (wbm_cyc_o),
        .wbm_stb_o            (wbm_stb_o),
        .wbm_cti_o            (wbm_cti_o),
        .wbm_bte_o            (wbm_bte_o),
        .wbm_dat_i            (wbm_dat_i),
        .wbm_ack_i            (wbm_ack_i),
        .wbm_err_i            (wbm_err_i),
        .wbm_rty_i            (wbm_rty_i)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    function automatic logic [31:0] exp_data(input logic [31:0] a);
        logic [31:0] w;
        w = mem_word(a);
`ifdef SUBLIME_WAVETABLE_DMA_BYTESWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    // Zero-wait slave: ack every strobed cycle; err/rty injected on a chosen attempt index.
    assign wbm_ack_i = (wbm_cyc_o & wbm_stb_o) | stray;
    assign wbm_err_i = (wbm_cyc_o && inj_mode == 2'd1 && attempt == inj_idx) | stray;
    assign wbm_rty_i = (wbm_cyc_o && inj_mode == 2'd2 && attempt == inj_idx) | stray;
    assign wbm_dat_i = stray ? 32'hDEAD_BEEF : mem_word(wbm_adr_o);

    always @(posedge clk) begin
        if (!busy) attempt <= 0;
        else if (wbm_cyc_o) attempt <= attempt + 1;
    end

    // Monitor: log write-port pulses, accepted beats, bursts, gaps and done pulses.
    always @(negedge clk) begin
        if (we0) begin w0_addr.push_back(wr_addr); w0_data.push_back(wr_data); end
        if (we1) begin w1_addr.push_back(wr_addr); w1_data.push_back(wr_data); end
        if (wbm_cyc_o && wbm_ack_i && !wbm_err_i && !wbm_rty_i) begin
            beat_adr.push_back(wbm_adr_o);
            beat_cti.push_back(wbm_cti_o);
        end
        if (wbm_cyc_o && !prev_cyc) begin
            burst_cnt <= burst_cnt + 1;
            if (had_burst) gaps.push_back(low_run);
        end
        done_cnt  <= done_cnt + (done ? 1 : 0);
        had_burst <= wbm_cyc_o ? 1'b1 : (busy ? had_burst : 1'b0);
        low_run   <= wbm_cyc_o ? 0 : low_run + 1;
        prev_cyc  <= wbm_cyc_o;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic do_start(input logic [31:0] s, input logic [13:0] len,
                            input logic tbl, input logic [12:0] off);
        src_addr   = s;
        length     = len;
        dst_table  = tbl;
        dst_offset = off;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, {63'd0, done}, 64'd1);
        @(negedge clk);
        check_eq({tag, "_single"}, {63'd0, done}, 64'd0);
        @(negedge clk);
    endtask

    initial begin
        int b0, b1, bb, bc, bd, bg;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_busy", {63'd0, busy}, 64'd0);
        check_eq("rst_done", {63'd0, done}, 64'd0);
        check_eq("rst_error", {63'd0, error}, 64'd0);
        check_eq("rst_cyc", {63'd0, wbm_cyc_o}, 64'd0);
        check_eq("rst_stb", {63'd0, wbm_stb_o}, 64'd0);
        check_eq("rst_we", {62'd0, we1, we0}, 64'd0);
        check_eq("rst_sel", {60'd0, wbm_sel_o}, 64'hf);
        check_eq("rst_wbwe_bte", {61'd0, wbm_we_o, wbm_bte_o}, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Length 20 into table 0: bursts of 8, 8, 4
        b0 = w0_addr.size(); b1 = w1_addr.size(); bb = beat_adr.size();
        bc = burst_cnt; bd = done_cnt; bg = gaps.size();
        do_start(32'h0000_1000, 14'd20, 1'b0, 13'd0);
        check_eq("t1_busy_rise", {63'd0, busy}, 64'd1);
        check_eq("t1_cyc_rise", {63'd0, wbm_cyc_o}, 64'd1);
        wait_done("t1_done", 200);
        check_eq("t1_busy_end", {63'd0, busy}, 64'd0);
        check_eq("t1_w0_count", 64'(w0_addr.size() - b0), 64'd20);
        check_eq("t1_w1_count", 64'(w1_addr.size() - b1), 64'd0);
        for (int i = 0; i < 20 && b0 + i < w0_addr.size(); i++) begin
            check_eq("t1_waddr", 64'(w0_addr[b0 + i]), 64'(i));
            check_eq("t1_wdata", 64'(w0_data[b0 + i]), 64'(exp_data(32'h1000 + 32'(4 * i))));
        end
        check_eq("t1_beats", 64'(beat_adr.size() - bb), 64'd20);
        for (int i = 0; i < 20 && bb + i < beat_adr.size(); i++) begin
            check_eq("t1_adr", 64'(beat_adr[bb + i]), 64'(32'h1000 + 32'(4 * i)));
            check_eq("t1_cti", 64'(beat_cti[bb + i]),
                     (i == 7 || i == 15 || i == 19) ? 64'h7 : 64'h2);
        end
        check_eq("t1_bursts", 64'(burst_cnt - bc), 64'd3);
        check_eq("t1_gap_count", 64'(gaps.size() - bg), 64'd2);
        for (int i = bg; i < gaps.size(); i++) check_eq("t1_gap_len", 64'(gaps[i]), 64'd1);
        check_eq("t1_done_cnt", 64'(done_cnt - bd), 64'd1);

        // Table 1 with destination wrap
        b0 = w0_addr.size(); b1 = w1_addr.size(); bd = done_cnt;
        do_start(32'h0000_2000, 14'd4, 1'b1, 13'd8190);
        wait_done("t2_done", 100);
        check_eq("t2_w0_count", 64'(w0_addr.size() - b0), 64'd0);
        check_eq("t2_w1_count", 64'(w1_addr.size() - b1), 64'd4);
        for (int i = 0; i < 4 && b1 + i < w1_addr.size(); i++) begin
            check_eq("t2_waddr", 64'(w1_addr[b1 + i]), 64'((8190 + i) % 8192));
            check_eq("t2_wdata", 64'(w1_data[b1 + i]), 64'(exp_data(32'h2000 + 32'(4 * i))));
        end
        check_eq("t2_done_cnt", 64'(done_cnt - bd), 64'd1);

        // Zero length
        bc = burst_cnt; bd = done_cnt;
        do_start(32'h0000_3000, 14'd0, 1'b0, 13'd5);
        check_eq("t3_done_next", {63'd0, done}, 64'd1);
        check_eq("t3_busy", {63'd0, busy}, 64'd0);
        check_eq("t3_cyc", {63'd0, wbm_cyc_o}, 64'd0);
        wait_done("t3_done", 4);
        check_eq("t3_error", {63'd0, error}, 64'd0);
        check_eq("t3_bursts", 64'(burst_cnt - bc), 64'd0);
        check_eq("t3_done_cnt", 64'(done_cnt - bd), 64'd1);

        // Bus error on beat 3 of 8
        b0 = w0_addr.size(); bd = done_cnt;
        inj_mode = 2'd1; inj_idx = 2;
        do_start(32'h0000_3000, 14'd8, 1'b0, 13'd100);
        wait_done("t4_done", 100);
        inj_mode = 2'd0;
        check_eq("t4_writes", 64'(w0_addr.size() - b0), 64'd2);
        for (int i = 0; i < 2 && b0 + i < w0_addr.size(); i++) begin
            check_eq("t4_waddr", 64'(w0_addr[b0 + i]), 64'(100 + i));
            check_eq("t4_wdata", 64'(w0_data[b0 + i]), 64'(exp_data(32'h3000 + 32'(4 * i))));
        end
        check_eq("t4_error", {63'd0, error}, 64'd1);
        check_eq("t4_done_cnt", 64'(done_cnt - bd), 64'd1);

        // Retry on beat 5 of 8; the start also clears the sticky error
        b0 = w0_addr.size(); bb = beat_adr.size(); bc = burst_cnt; bg = gaps.size();
        inj_mode = 2'd2; inj_idx = 4;
        do_start(32'h0000_4000, 14'd8, 1'b0, 13'd200);
        check_eq("t5_error_clr", {63'd0, error}, 64'd0);
        wait_done("t5_done", 100);
        inj_mode = 2'd0;
        check_eq("t5_writes", 64'(w0_addr.size() - b0), 64'd8);
        for (int i = 0; i < 8 && b0 + i < w0_addr.size(); i++) begin
            check_eq("t5_waddr", 64'(w0_addr[b0 + i]), 64'(200 + i));
            check_eq("t5_wdata", 64'(w0_data[b0 + i]), 64'(exp_data(32'h4000 + 32'(4 * i))));
        end
        check_eq("t5_bursts", 64'(burst_cnt - bc), 64'd2);
        if (bb + 7 < beat_adr.size()) begin
            check_eq("t5_reissue_adr", 64'(beat_adr[bb + 4]), 64'h4010);
            check_eq("t5_cti_cut", 64'(beat_cti[bb + 3]), 64'h2);
            check_eq("t5_cti_last", 64'(beat_cti[bb + 7]), 64'h7);
        end else begin
            check_eq("t5_beat_log", 64'(beat_adr.size() - bb), 64'd8);
        end
        if (gaps.size() > bg) check_eq("t5_gap_len", 64'(gaps[bg]), 64'd1);
        else check_eq("t5_gap_seen", 64'(gaps.size() - bg), 64'd1);
        check_eq("t5_error", {63'd0, error}, 64'd0);

        // Stray responses while idle are ignored
        b0 = w0_addr.size(); b1 = w1_addr.size(); bd = done_cnt;
        stray = 1'b1;
        @(negedge clk);
        @(negedge clk);
        stray = 1'b0;
        @(negedge clk);
        check_eq("t6_no_write", 64'((w0_addr.size() - b0) + (w1_addr.size() - b1)), 64'd0);
        check_eq("t6_error", {63'd0, error}, 64'd0);
        check_eq("t6_done", 64'(done_cnt - bd), 64'd0);

        // Reset mid-burst, with a start pulse issued while busy
        b1 = w1_addr.size(); bc = burst_cnt; bd = done_cnt;
        do_start(32'h0000_5000, 14'd20, 1'b0, 13'd0);
        @(negedge clk);
        do_start(32'h0000_6000, 14'd4, 1'b1, 13'd300);
        @(negedge clk);
        check_eq("t7_one_burst", 64'(burst_cnt - bc), 64'd1);
        check_eq("t7_no_w1", 64'(w1_addr.size() - b1), 64'd0);
        #2;
        rst = 1'b0;
        #1;
        check_eq("t7_rst_cyc", {62'd0, wbm_cyc_o, wbm_stb_o}, 64'd0);
        check_eq("t7_rst_busy", {63'd0, busy}, 64'd0);
        check_eq("t7_rst_we", {62'd0, we1, we0}, 64'd0);
        check_eq("t7_rst_flags", {62'd0, done, error}, 64'd0);
        @(negedge clk);
        b0 = w0_addr.size(); b1 = w1_addr.size(); bc = burst_cnt;
        rst = 1'b1;
        for (int i = 0; i < 30; i++) @(negedge clk);
        check_eq("t7_no_done", 64'(done_cnt - bd), 64'd0);
        check_eq("t7_no_bursts", 64'(burst_cnt - bc), 64'd0);
        check_eq("t7_no_writes", 64'((w0_addr.size() - b0) + (w1_addr.size() - b1)), 64'd0);
        check_eq("t7_idle", {63'd0, busy}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
